// File: rtl/encoder83_pkg.sv
// Shared types and constants for the registered 8-to-3 event encoder.
package encoder83_pkg;

  localparam int unsigned N_LINES = 8;
  localparam int unsigned IDX_W   = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE,
    PRESSED
  } state_t;

  localparam idx_t             A_N_IDLE = 3'b111;
  localparam logic [N_LINES:0] SYNC_RST = '1;

  // Highest set bit wins; later iterations overwrite lower indices.
  function automatic idx_t prio_idx(input logic [N_LINES-1:0] req);
    idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      if (req[i]) idx = idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/encoder83_event_if.sv
// Key-code event handshake between the encoder and its consumer.
interface encoder83_event_if;
  import encoder83_pkg::*;

  idx_t code;
  logic code_valid;
  logic code_ready;
  logic overrun;

  modport master (output code, output code_valid, output overrun, input code_ready);
  modport slave  (input code, input code_valid, input overrun, output code_ready);
endinterface

// File: rtl/encoder83_event_debounce_sync.sv
// Two-flop synchroniser followed by a stability counter; stable only follows
// a value that has been held for DB_CYCLES consecutive cycles.
module debounce_sync #(
  parameter int unsigned W         = 9,
  parameter int unsigned DB_CYCLES = 16,
  parameter logic [W-1:0] RST_VAL  = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [W-1:0]     sync1_q, sync1_d;
  logic [W-1:0]     sync2_q, sync2_d;
  logic [W-1:0]     cand_q, cand_d;
  logic [W-1:0]     stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = din;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      stable_d = cand_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= RST_VAL;
      sync2_q  <= RST_VAL;
      cand_q   <= RST_VAL;
      stable_q <= RST_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/encoder83_event.sv
// Registered 74148-style priority encoder with debounced inputs; each new
// winning request line is issued once as a code on a valid/ready handshake.
module encoder83_event
  import encoder83_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ei_n,
  input  logic [N_LINES-1:0] i_n,
  output idx_t               a_n,
  output logic               gs_n,
  output logic               eo_n,
  encoder83_event_if.master  evt
);

  logic [N_LINES:0]   stable;
  logic               enabled, any, active;
  logic [N_LINES-1:0] req;
  idx_t               idx;
  logic               issue, xfer, accept;

  idx_t   a_n_q, a_n_d;
  logic   gs_n_q, gs_n_d;
  logic   eo_n_q, eo_n_d;
  state_t state_q, state_d;
  idx_t   last_idx_q, last_idx_d;
  idx_t   code_q, code_d;
  logic   code_valid_q, code_valid_d;
  logic   overrun_q, overrun_d;

  debounce_sync #(
    .W        (N_LINES + 1),
    .DB_CYCLES(DB_CYCLES),
    .RST_VAL  (SYNC_RST)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .din   ({ei_n, i_n}),
    .stable(stable)
  );

  always_comb begin
    enabled = ~stable[N_LINES];
    req     = ~stable[N_LINES-1:0];
    any     = |req;
    idx     = prio_idx(req);
    active  = enabled & any;

    a_n_d  = active ? ~idx : A_N_IDLE;
    gs_n_d = ~active;
    eo_n_d = ~(enabled & ~any);

    state_d    = state_q;
    last_idx_d = last_idx_q;
    issue      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (active) begin
          state_d    = PRESSED;
          last_idx_d = idx;
          issue      = 1'b1;
        end
      end
      PRESSED: begin
        if (!active) begin
          state_d = IDLE;
        end else if (idx != last_idx_q) begin
          last_idx_d = idx;
          issue      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The stored index tracks every detected change, even a dropped one,
    // so a held key does not keep generating drops.
    xfer         = code_valid_q & evt.code_ready;
    accept       = issue & (~code_valid_q | xfer);
    code_d       = code_q;
    code_valid_d = code_valid_q;
    overrun_d    = overrun_q;
    if (xfer) begin
      code_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end
    if (accept) begin
      code_d       = idx;
      code_valid_d = 1'b1;
    end
    if (issue && !accept) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_n_q        <= A_N_IDLE;
      gs_n_q       <= 1'b1;
      eo_n_q       <= 1'b1;
      state_q      <= IDLE;
      last_idx_q   <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      a_n_q        <= a_n_d;
      gs_n_q       <= gs_n_d;
      eo_n_q       <= eo_n_d;
      state_q      <= state_d;
      last_idx_q   <= last_idx_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign a_n            = a_n_q;
  assign gs_n           = gs_n_q;
  assign eo_n           = eo_n_q;
  assign evt.code       = code_q;
  assign evt.code_valid = code_valid_q;
  assign evt.overrun    = overrun_q;

endmodule
